// File: rtl/multi_early_debouncer.sv
// N-channel early debouncer: the output follows the first synchronised edge at once, then
// ignores the input for LOCK_CYCLES. Per-channel raw/debounced rising-edge counters, one readable at a time.
module multi_early_debouncer #(
   parameter int N_CH        = 4,
   parameter int LOCK_CYCLES = 2_000_000,
   parameter int CNT_W       = 8,
   parameter int SEL_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_CH-1:0]  sw,
   input  logic             clr,
   input  logic [SEL_W-1:0] sel,
   output logic [N_CH-1:0]  db,
   output logic [N_CH-1:0]  db_rise,
   output logic [N_CH-1:0]  db_fall,
   output logic [CNT_W-1:0] raw_cnt,
   output logic [CNT_W-1:0] db_cnt
);
   // state | meaning
   // ZERO  | debounced low, waiting for s2 to go high
   // WAIT1 | debounced high, input ignored until the lockout expires
   // ONE   | debounced high, waiting for s2 to go low
   // WAIT0 | debounced low, input ignored until the lockout expires
   typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} state_e;

   localparam int TMR_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES + 1) : 1;
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(LOCK_CYCLES - 1);

   logic [N_CH-1:0]  s1_q, s2_q, s3_q;
   logic [N_CH-1:0]  raw_edge_q;
   logic [N_CH-1:0]  db_dly_q;
   logic [CNT_W-1:0] raw_c_q [N_CH];
   logic [CNT_W-1:0] dbc_q   [N_CH];

   genvar g;
   for (g = 0; g < N_CH; g++) begin : g_ch
      state_e           state_q, state_d;
      logic [TMR_W-1:0] tmr_q, tmr_d;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            state_q <= ZERO;
            tmr_q   <= '0;
         end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
         end
      end

      // The timer is loaded with LOCK_CYCLES-1 so a WAIT entered at edge T exits at T+LOCK_CYCLES.
      always_comb begin
         state_d = state_q;
         tmr_d   = tmr_q;
         unique case (state_q)
            ZERO:  if (s2_q[g]) begin
                      state_d = WAIT1;
                      tmr_d   = TMR_LOAD;
                   end
            WAIT1: if (tmr_q == '0) state_d = ONE;
                   else             tmr_d   = tmr_q - TMR_W'(1);
            ONE:   if (!s2_q[g]) begin
                      state_d = WAIT0;
                      tmr_d   = TMR_LOAD;
                   end
            WAIT0: if (tmr_q == '0) state_d = ZERO;
                   else             tmr_d   = tmr_q - TMR_W'(1);
            default: state_d = ZERO;
         endcase
      end

      assign db[g] = (state_q == WAIT1) || (state_q == ONE);
   end

   assign db_rise = db & ~db_dly_q;
   assign db_fall = ~db & db_dly_q;

   // raw_edge is registered so raw and debounced counts land on the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_q       <= '0;
         s2_q       <= '0;
         s3_q       <= '0;
         raw_edge_q <= '0;
         db_dly_q   <= '0;
         for (int i = 0; i < N_CH; i++) begin
            raw_c_q[i] <= '0;
            dbc_q[i]   <= '0;
         end
      end else begin
         s1_q       <= sw;
         s2_q       <= s1_q;
         s3_q       <= s2_q;
         raw_edge_q <= s2_q & ~s3_q;
         db_dly_q   <= db;
         for (int i = 0; i < N_CH; i++) begin
            if (clr) begin
               raw_c_q[i] <= '0;
               dbc_q[i]   <= '0;
            end else begin
               if (raw_edge_q[i]) raw_c_q[i] <= raw_c_q[i] + CNT_W'(1);
               if (db_rise[i])    dbc_q[i]   <= dbc_q[i] + CNT_W'(1);
            end
         end
      end
   end

   always_comb begin
      raw_cnt = '0;
      db_cnt  = '0;
      if ({1'b0, sel} < (SEL_W + 1)'(N_CH)) begin
         raw_cnt = raw_c_q[sel];
         db_cnt  = dbc_q[sel];
      end
   end
endmodule

// File: tb/tb_multi_early_debouncer.sv
// Directed bench for multi_early_debouncer: vector table for reset/single press, hand sequences
// for bounce, wrap, clear, async reset and out-of-range select on a 3-channel instance.
module tb_multi_early_debouncer;
   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] sw;
   logic       clr;
   logic [1:0] sel;
   logic [3:0] db, db_rise, db_fall;
   logic [7:0] raw_cnt, db_cnt;

   logic [1:0] sel3;
   logic [2:0] db3, rise3, fall3;
   logic [7:0] raw3, dbc3;

   int n_checks = 0;
   int n_fail   = 0;

   multi_early_debouncer #(.N_CH(4), .LOCK_CYCLES(8), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .sw(sw), .clr(clr), .sel(sel),
      .db(db), .db_rise(db_rise), .db_fall(db_fall), .raw_cnt(raw_cnt), .db_cnt(db_cnt)
   );

   multi_early_debouncer #(.N_CH(3), .LOCK_CYCLES(8), .CNT_W(8)) dut3 (
      .clk(clk), .reset(reset), .sw(sw[2:0]), .clr(clr), .sel(sel3),
      .db(db3), .db_rise(rise3), .db_fall(fall3), .raw_cnt(raw3), .db_cnt(dbc3)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] sw;
      logic [1:0] sel;
      int         adv;
      logic [3:0] e_db, e_rise, e_fall;
      logic [7:0] e_raw, e_dbc;
      string      name;
   } vec_t;

   vec_t vecs [11];

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   int rises, falls;

   initial begin
      vecs[0]  = '{4'h0, 2'd0, 3, 4'h0, 4'h0, 4'h0, 8'd0, 8'd0, "idle_sel0"};
      vecs[1]  = '{4'h0, 2'd1, 3, 4'h0, 4'h0, 4'h0, 8'd0, 8'd0, "idle_sel1"};
      vecs[2]  = '{4'h0, 2'd2, 3, 4'h0, 4'h0, 4'h0, 8'd0, 8'd0, "idle_sel2"};
      vecs[3]  = '{4'h0, 2'd3, 3, 4'h0, 4'h0, 4'h0, 8'd0, 8'd0, "idle_sel3"};
      vecs[4]  = '{4'h1, 2'd0, 2, 4'h0, 4'h0, 4'h0, 8'd0, 8'd0, "press_e1"};
      vecs[5]  = '{4'h1, 2'd0, 1, 4'h1, 4'h1, 4'h0, 8'd0, 8'd0, "press_e2"};
      vecs[6]  = '{4'h1, 2'd0, 1, 4'h1, 4'h0, 4'h0, 8'd1, 8'd1, "press_e3"};
      vecs[7]  = '{4'h0, 2'd0, 7, 4'h1, 4'h0, 4'h0, 8'd1, 8'd1, "lockout_e10"};
      vecs[8]  = '{4'h0, 2'd0, 1, 4'h0, 4'h0, 4'h1, 8'd1, 8'd1, "fall_e11"};
      vecs[9]  = '{4'h0, 2'd0, 1, 4'h0, 4'h0, 4'h0, 8'd1, 8'd1, "fall_e12"};
      vecs[10] = '{4'h0, 2'd0, 8, 4'h0, 4'h0, 4'h0, 8'd1, 8'd1, "settle_e20"};

      reset = 1'b1; sw = 4'hF; clr = 1'b0; sel = 2'd0; sel3 = 2'd0;
      tick(3);
      check("rst_db",      32'(db),      32'h0);
      check("rst_db_rise", 32'(db_rise), 32'h0);
      check("rst_db_fall", 32'(db_fall), 32'h0);
      check("rst_raw_cnt", 32'(raw_cnt), 32'h0);
      check("rst_db_cnt",  32'(db_cnt),  32'h0);
      reset = 1'b0; sw = 4'h0;

      for (int i = 0; i < 11; i++) begin
         sw  = vecs[i].sw;
         sel = vecs[i].sel;
         tick(vecs[i].adv);
         check({vecs[i].name, "_db"},   32'(db),      32'(vecs[i].e_db));
         check({vecs[i].name, "_rise"}, 32'(db_rise), 32'(vecs[i].e_rise));
         check({vecs[i].name, "_fall"}, 32'(db_fall), 32'(vecs[i].e_fall));
         check({vecs[i].name, "_raw"},  32'(raw_cnt), 32'(vecs[i].e_raw));
         check({vecs[i].name, "_dbc"},  32'(db_cnt),  32'(vecs[i].e_dbc));
      end

      // bounce on channel 1: five raw rising edges, one debounced rise, no fall
      sel = 2'd1; rises = 0; falls = 0;
      for (int k = 0; k < 4; k++) begin
         sw[1] = 1'b1; tick(1); rises += int'(db_rise[1]); falls += int'(db_fall[1]);
         sw[1] = 1'b0; tick(1); rises += int'(db_rise[1]); falls += int'(db_fall[1]);
      end
      sw[1] = 1'b1;
      for (int k = 0; k < 24; k++) begin
         tick(1);
         rises += int'(db_rise[1]);
         falls += int'(db_fall[1]);
      end
      check("bounce_db1",    32'(db[1]),  32'h1);
      check("bounce_rises",  32'(rises),  32'd1);
      check("bounce_falls",  32'(falls),  32'd0);
      check("bounce_raw",    32'(raw_cnt), 32'd5);
      check("bounce_dbc",    32'(db_cnt),  32'd1);
      sw[1] = 1'b0;
      tick(24);
      check("bounce_rel_db1", 32'(db[1]),   32'h0);
      check("bounce_rel_raw", 32'(raw_cnt), 32'd5);

      // 256 clean presses on channel 2 wrap both counters
      sel = 2'd2;
      for (int k = 0; k < 256; k++) begin
         sw[2] = 1'b1; tick(14);
         sw[2] = 1'b0; tick(14);
      end
      check("wrap_raw", 32'(raw_cnt), 32'd0);
      check("wrap_dbc", 32'(db_cnt),  32'd0);
      sw[2] = 1'b1; tick(14);
      sw[2] = 1'b0; tick(14);
      check("wrap257_raw", 32'(raw_cnt), 32'd1);
      check("wrap257_dbc", 32'(db_cnt),  32'd1);
      sel = 2'd0;
      #1;
      check("indep_ch0_raw", 32'(raw_cnt), 32'd1);

      // out-of-range select on the 3-channel instance
      sel3 = 2'd3; #1;
      check("n3_sel3_raw", 32'(raw3), 32'd0);
      check("n3_sel3_dbc", 32'(dbc3), 32'd0);
      sel3 = 2'd0; #1;
      check("n3_sel0_raw", 32'(raw3), 32'd1);
      check("n3_sel0_dbc", 32'(dbc3), 32'd1);
      sel3 = 2'd1; #1;
      check("n3_sel1_raw", 32'(raw3), 32'd5);
      check("n3_sel1_dbc", 32'(dbc3), 32'd1);
      sel3 = 2'd2; #1;
      check("n3_sel2_raw", 32'(raw3), 32'd1);

      // clear held across the edges where channel 3's increments land
      sel = 2'd3;
      sw[3] = 1'b1; tick(1);
      clr = 1'b1; tick(3);
      clr = 1'b0;
      check("clr_db3",  32'(db[3]),   32'h1);
      check("clr_raw3", 32'(raw_cnt), 32'd0);
      check("clr_dbc3", 32'(db_cnt),  32'd0);
      tick(1);
      check("clr_raw3_later", 32'(raw_cnt), 32'd0);
      sel = 2'd0; #1;
      check("clr_raw0", 32'(raw_cnt), 32'd0);
      sel3 = 2'd1; #1;
      check("clr_n3_raw1", 32'(raw3), 32'd0);

      // asynchronous reset mid-WAIT1 on channel 0
      tick(20);
      sw[0] = 1'b1; tick(4);
      check("wait1_db0", 32'(db[0]), 32'h1);
      #3 reset = 1'b1;
      #1;
      check("async_rst_db", 32'(db), 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      tick(2);
      check("rst_rel_e1_db", 32'(db), 32'h0);
      tick(1);
      check("rst_rel_e2_db",   32'(db),      32'h9);
      check("rst_rel_e2_rise", 32'(db_rise), 32'h9);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/multi_early_debouncer.md
# multi_early_debouncer

Parametrised N-channel early-detection debouncer with per-channel bounce statistics. Each switch input is synchronised and passed through an early debouncer: the output follows the first input edge immediately, then ignores the input for a fixed lockout. Per-channel counters record raw and debounced rising edges, and one channel at a time is selected for readout. The block feeds the seven-segment display path and replaces a chain of separate debouncer, edge-detector and counter instances.

## Interface
- N_CH, 4, number of switch channels (≥1)
- LOCK_CYCLES, 2_000_000, lockout length in clk cycles (≥1; 20 ms at 100 MHz)
- CNT_W, 8, width of each edge counter
- SEL_W, $clog2(N_CH) (min 1), width of channel select

- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-high; clears every register
- sw  input  N_CH  raw, asynchronous switch levels
- clr  input  1  synchronous clear of all edge counters
- sel  input  SEL_W  channel whose counts appear on raw_cnt/db_cnt
- db  output  N_CH  debounced levels
- db_rise  output  N_CH  one-cycle pulse on each debounced 0→1
- db_fall  output  N_CH  one-cycle pulse on each debounced 1→0
- raw_cnt  output  CNT_W  rising edges of the synchronised raw input, channel sel
- db_cnt  output  CNT_W  rising edges of db, channel sel

## Operation
- Per channel: 2-flop synchroniser (s1, s2) and a third flop s3 for raw edge detection. raw_edge = s2 & ~s3.
- Per-channel Moore FSM; db = 1 in WAIT1 and ONE:
  - ZERO: s2=1 → WAIT1, load timer; otherwise stay.
  - WAIT1: input ignored; timer counts down; when LOCK_CYCLES cycles have elapsed → ONE.
  - ONE: s2=0 → WAIT0, load timer; otherwise stay.
  - WAIT0: input ignored; when LOCK_CYCLES cycles have elapsed → ZERO.
- Leaving a WAIT state ignores the input level. If the input has already reverted, the next cycle starts the opposite transition from ONE or ZERO.
- Timer width is $clog2(LOCK_CYCLES+1) per channel. Timers are independent.
- db_rise[i] = db[i] & ~db_d[i] and db_fall[i] = ~db[i] & db_d[i], where db_d is a registered copy of db.
- Counters: raw_c[i] increments on raw_edge[i]; dbc[i] increments on db_rise[i]. Both wrap modulo 2^CNT_W and have no saturation.
- clr=1: all counters go to 0 on the next edge. clr beats a simultaneous increment, so the result is 0.
- Readout: raw_cnt = raw_c[sel] and db_cnt = dbc[sel], combinational from the counter registers. If sel ≥ N_CH, both outputs are 0.
- Reset: all states go to ZERO, timers 0, s1/s2/s3/db_d 0, counters 0. Outputs are therefore db=0, db_rise=0, db_fall=0, raw_cnt=0, db_cnt=0.
- Reset asserted mid-WAIT forces ZERO immediately; after release, a still-high input restarts the WAIT1 sequence.

## Timing
- Input change settled before edge E0: s1 updates at E0, s2 at E1, FSM state at E2.
  - db changes after E2, a latency of 3 edges.
  - db_rise/db_fall are high for exactly the cycle following E2.
  - raw counter updates at E3 and db counter at E3, so both are visible after E3.
- Entering WAIT at edge T leaves it at edge T+LOCK_CYCLES. The earliest opposite db change is therefore LOCK_CYCLES+1 edges after the first change.
- Minimum debounced period is 2·(LOCK_CYCLES+1) cycles. Faster input toggles are absorbed, but every synchronised raw edge is still counted.
- Channels are fully independent. Simultaneous edges on all channels are each counted.

## Test plan
Bench parameters: N_CH=4, LOCK_CYCLES=8, CNT_W=8.

1. Reset held with sw=4'hF, then released with sw=0 → all outputs 0 during reset. After release, db stays 0 and both counts on every sel stay 0.
2. sw[0] 0→1 held, sel=0 → db[0] high 3 edges later; db_rise[0] is a single-cycle pulse; raw_cnt=1 and db_cnt=1 after the 4th edge. Releasing sw[0] produces a db_fall[0] pulse, with db low no earlier than 9 edges after the rise.
3. sw[1] bounces as 5 rising edges spaced 2 cycles apart, then holds 1, sel=1 → db[1] rises once and does not fall. Result: raw_cnt=5, db_cnt=1.
4. 256 clean press/release cycles on sw[2], sel=2 → both counts wrap to 0. A 257th press gives 1.
5. clr asserted in the same cycle as raw_edge[3] → raw_cnt and db_cnt for channel 3 read 0, not 1. Reset asserted mid-WAIT1 on channel 0 → db[0] drops to 0 without waiting for the next clock edge.
6. Separate elaboration with N_CH=3, sel=3 → raw_cnt=0 and db_cnt=0 while channels 0–2 hold nonzero counts.
